// File: rtl/irq_arbiter_if.sv
// rtl/irq_arbiter_if.sv - bridge register port (Addr/WE/DataIn/DataOut) for irq_arbiter
interface irq_arbiter_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport master (output Addr, WE, DataIn, input DataOut);
  modport slave  (input Addr, WE, DataIn, output DataOut);
endinterface

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - edge-capturing interrupt arbiter with fixed/round-robin priority and EOI
module irq_arbiter #(
  parameter int          N_SRC = 6,
  parameter logic [31:0] BASE  = 32'h0000_7F20
) (
  input  logic             clk,
  input  logic             reset,
  irq_arbiter_if.slave     bus,
  input  logic [N_SRC-1:0] src_irq,
  output logic             cpu_irq,
  output logic [2:0]       cpu_id,
  input  logic             cpu_ack
);
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, SERVICE = 2'b10} state_t;

  state_t           state, state_d;
  logic             gen, rr;
  logic [N_SRC-1:0] mask, pend, src_prev;
  logic [2:0]       rr_ptr, rr_ptr_d, cur_id, cur_id_d;
  logic             cpu_irq_d, ack_clr;

  logic             sel, wr_ctrl, wr_mask, wr_pend, eoi;
  logic [N_SRC-1:0] elig, rise, w1c_bits, ack_bits;
  logic [2:0]       start, win, nxt_ptr;
  logic             any_elig, elig_cur;
  logic             unused_bits;

  assign sel     = (bus.Addr[31:4] == BASE[31:4]);
  assign wr_ctrl = sel && bus.WE && (bus.Addr[3:2] == 2'b00);
  assign wr_mask = sel && bus.WE && (bus.Addr[3:2] == 2'b01);
  assign wr_pend = sel && bus.WE && (bus.Addr[3:2] == 2'b10);
  assign eoi     = sel && bus.WE && (bus.Addr[3:2] == 2'b11);
  assign unused_bits = ^{bus.Addr[1:0], bus.DataIn[31:N_SRC]};

  assign rise     = src_irq & ~src_prev;
  assign elig     = pend & mask & {N_SRC{gen}};
  assign elig_cur = |(elig & (N_SRC'(1) << cur_id));
  assign w1c_bits = wr_pend ? bus.DataIn[N_SRC-1:0] : '0;
  assign ack_bits = ack_clr ? (N_SRC'(1) << cur_id) : '0;
  assign nxt_ptr  = (cur_id == 3'(N_SRC - 1)) ? 3'd0 : cur_id + 3'd1;
  assign start    = rr ? rr_ptr : 3'd0;
  assign cpu_id   = cur_id;

  // Fixed priority is round-robin anchored at 0: pick the eligible source closest after start.
  always_comb begin
    int best;
    int d;
    best     = N_SRC;
    d        = 0;
    win      = 3'd0;
    any_elig = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      d = i - int'(start);
      if (d < 0) d = d + N_SRC;
      if (elig[i] && d < best) begin
        best     = d;
        win      = 3'(i);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    cpu_irq_d = cpu_irq;
    cur_id_d  = cur_id;
    rr_ptr_d  = rr_ptr;
    ack_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (any_elig) begin
          cur_id_d  = win;
          cpu_irq_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (cpu_ack) begin
          ack_clr   = 1'b1;
          cpu_irq_d = 1'b0;
          rr_ptr_d  = nxt_ptr;
          state_d   = SERVICE;
        end else if (!elig_cur) begin
          cpu_irq_d = 1'b0;
          state_d   = IDLE;
        end
      end
      SERVICE: begin
        cpu_irq_d = 1'b0;
        if (eoi) state_d = IDLE;
      end
      default: begin
        cpu_irq_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cpu_irq  <= 1'b0;
      cur_id   <= 3'd0;
      rr_ptr   <= 3'd0;
      gen      <= 1'b0;
      rr       <= 1'b0;
      mask     <= '0;
      pend     <= '0;
      src_prev <= '0;
    end else begin
      state    <= state_d;
      cpu_irq  <= cpu_irq_d;
      cur_id   <= cur_id_d;
      rr_ptr   <= rr_ptr_d;
      src_prev <= src_irq;
      // New edges are OR-ed in last so they win over W1C and ack clears.
      pend     <= (pend & ~w1c_bits & ~ack_bits) | rise;
      if (wr_ctrl) begin
        gen <= bus.DataIn[0];
        rr  <= bus.DataIn[1];
      end
      if (wr_mask) mask <= bus.DataIn[N_SRC-1:0];
    end
  end

  always_comb begin
    bus.DataOut = 32'd0;
    if (sel) begin
      case (bus.Addr[3:2])
        2'b00:   bus.DataOut = {30'd0, rr, gen};
        2'b01:   bus.DataOut = 32'(mask);
        2'b10:   bus.DataOut = 32'(pend);
        default: bus.DataOut = {(state != IDLE), 21'd0, state, 5'd0, cur_id};
      endcase
    end
  end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - directed self-checking bench for irq_arbiter
module tb_irq_arbiter;
  localparam logic [31:0] A_CTRL = 32'h0000_7F20;
  localparam logic [31:0] A_MASK = 32'h0000_7F24;
  localparam logic [31:0] A_PEND = 32'h0000_7F28;
  localparam logic [31:0] A_CUR  = 32'h0000_7F2C;
  localparam logic [31:0] A_OFF  = 32'h0000_7F00;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] src_irq = '0;
  logic       cpu_irq;
  logic [2:0] cpu_id;
  logic       cpu_ack = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [31:0] rd;

  irq_arbiter_if bus ();

  irq_arbiter #(.N_SRC(6), .BASE(32'h0000_7F20)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .src_irq(src_irq), .cpu_irq(cpu_irq), .cpu_id(cpu_id), .cpu_ack(cpu_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.Addr = a; bus.WE = 1'b1; bus.DataIn = d;
    tick();
    bus.WE = 1'b0; bus.Addr = 32'd0; bus.DataIn = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.Addr = a; bus.WE = 1'b0;
    #1;
    d = bus.DataOut;
    bus.Addr = 32'd0;
  endtask

  task automatic wait_irq(input string tag, input logic [2:0] exp_id);
    int n;
    n = 0;
    while (!cpu_irq && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_irq"}, 32'(cpu_irq), 32'd1);
    check({tag, "_id"}, 32'(cpu_id), 32'(exp_id));
  endtask

  task automatic ack_eoi();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    bus_write(A_CUR, 32'd0);
  endtask

  initial begin
    bus.Addr = 32'd0; bus.WE = 1'b0; bus.DataIn = 32'd0;
    repeat (3) tick();
    bus_read(A_CTRL, rd); check("rst_dataout", rd, 32'd0);
    reset = 1'b1;
    tick();
    check("rst_irq", 32'(cpu_irq), 32'd0);
    check("rst_id", 32'(cpu_id), 32'd0);
    bus_read(A_CUR, rd);  check("rst_cur", rd, 32'd0);
    bus_read(A_PEND, rd); check("rst_pend", rd, 32'd0);

    // basic flow
    bus_write(A_CTRL, 32'h1);
    bus_write(A_MASK, 32'hFFFF_FF01);
    bus_read(A_MASK, rd); check("mask_rsvd", rd, 32'h01);
    bus_write(A_OFF, 32'h3);
    bus_read(A_CTRL, rd); check("unsel_wr", rd, 32'h1);
    bus_read(A_OFF, rd);  check("unsel_rd", rd, 32'h0);
    src_irq = 6'h01;
    tick();
    bus_read(A_PEND, rd); check("t1_pend", rd, 32'h01);
    check("t1_irq_early", 32'(cpu_irq), 32'd0);
    tick();
    check("t2_irq", 32'(cpu_irq), 32'd1);
    check("t2_id", 32'(cpu_id), 32'd0);
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    check("ack_irq", 32'(cpu_irq), 32'd0);
    bus_read(A_PEND, rd); check("ack_pend", rd, 32'h0);
    bus_read(A_CUR, rd);  check("svc_cur", rd, 32'h8000_0200);
    bus_write(A_CUR, 32'd0);
    bus_read(A_CUR, rd);  check("eoi_cur", rd, 32'h0);
    src_irq = 6'h00; tick();

    // fixed priority
    bus_write(A_MASK, 32'h3F);
    src_irq = 6'h24;
    wait_irq("fix_first", 3'd2);
    ack_eoi();
    wait_irq("fix_second", 3'd5);
    ack_eoi();
    src_irq = 6'h00; tick();

    // round robin; rr_ptr wrapped from 5 to 0 on the last ack
    bus_write(A_CTRL, 32'h3);
    src_irq = 6'h03;
    for (int k = 0; k < 4; k++) begin
      wait_irq($sformatf("rr%0d", k), (k % 2 == 0) ? 3'd0 : 3'd1);
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      src_irq = 6'h00; tick();
      src_irq = 6'h03;
      bus_write(A_CUR, 32'd0);
    end
    bus_write(A_CTRL, 32'h0);
    tick();
    check("gen_off_irq", 32'(cpu_irq), 32'd0);
    bus_write(A_PEND, 32'h3F);
    bus_read(A_PEND, rd); check("w1c_all", rd, 32'h0);
    src_irq = 6'h00; tick();

    // withdraw by masking
    bus_write(A_CTRL, 32'h1);
    src_irq = 6'h08;
    wait_irq("wd_req", 3'd3);
    bus_write(A_MASK, 32'h0);
    tick();
    check("wd_irq", 32'(cpu_irq), 32'd0);
    bus_read(A_CUR, rd);  check("wd_cur", rd, 32'h3);
    bus_read(A_PEND, rd); check("wd_pend", rd, 32'h08);
    bus_write(A_MASK, 32'h08);
    wait_irq("wd_rereq", 3'd3);
    ack_eoi();
    src_irq = 6'h00; tick();

    // set beats W1C on the same bit
    src_irq = 6'h04;
    bus_write(A_PEND, 32'h04);
    bus_read(A_PEND, rd); check("set_wins", rd, 32'h04);
    bus_write(A_PEND, 32'h04);
    bus_read(A_PEND, rd); check("w1c_only", rd, 32'h0);
    src_irq = 6'h00; tick();

    // async reset mid-REQ
    bus_write(A_MASK, 32'h04);
    src_irq = 6'h04;
    wait_irq("ar_req", 3'd2);
    #2 reset = 1'b0;
    #1;
    check("ar_irq", 32'(cpu_irq), 32'd0);
    src_irq = 6'h00;
    tick();
    reset = 1'b1;
    tick();
    bus_read(A_CTRL, rd); check("ar_ctrl", rd, 32'h0);
    bus_read(A_MASK, rd); check("ar_mask", rd, 32'h0);
    bus_read(A_PEND, rd); check("ar_pend", rd, 32'h0);
    bus_read(A_CUR, rd);  check("ar_cur", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
